// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage, the data stage and the memory port arbiter.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    FIN
  } state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and byte-memory signals of the shared memory port.
// The slave modport is the arbiter's view; the master modport is the CPU/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16
);
  import cpu_pkg::*;

  logic                fetch_req;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                fetch_flush;
  logic                fetch_ack;
  logic [WORD_W-1:0]   fetch_rdata;

  logic                data_req;
  logic                data_we;
  logic [ADDR_W-1:0]   data_addr;
  logic [WORD_W-1:0]   data_wdata;
  logic                data_ack;
  logic [WORD_W-1:0]   data_rdata;

  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [BYTE_W-1:0]   mem_wdata;
  logic [BYTE_W-1:0]   mem_rdata;

  logic                busy;

  modport slave (
    input  fetch_req, fetch_addr, fetch_flush, data_req, data_we, data_addr, data_wdata,
           mem_rdata,
    output fetch_ack, fetch_rdata, data_ack, data_rdata, mem_en, mem_we, mem_addr,
           mem_wdata, busy
  );

  modport master (
    output fetch_req, fetch_addr, fetch_flush, data_req, data_we, data_addr, data_wdata,
           mem_rdata,
    input  fetch_ack, fetch_rdata, data_ack, data_rdata, mem_en, mem_we, mem_addr,
           mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide memory between fetch and data stages; each 16-bit word is two
// big-endian byte accesses (HI then LO), acked in FIN. Data wins unless fetch has starved.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned MAX_DATA_BURST = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [2:0] BurstMax = 3'(MAX_DATA_BURST);

  state_e              state_q;
  owner_e              owner_q;
  logic [2:0]          burst_q;
  logic                abort_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [BYTE_W-1:0]   mem_wdata_q;
  logic [BYTE_W-1:0]   lo_wdata_q;
  logic [BYTE_W-1:0]   hi_rdata_q;
  logic [WORD_W-1:0]   fetch_rdata_q;
  logic [WORD_W-1:0]   data_rdata_q;

  logic                fetch_ok;
  logic                grant_fetch;
  logic                grant_data;
  logic                in_fin;
  logic [WORD_W-1:0]   fin_word;

  // A flush in IDLE withdraws the fetch request for this cycle only.
  assign fetch_ok    = bus.fetch_req & ~bus.fetch_flush;
  assign grant_fetch = fetch_ok & (~bus.data_req | (burst_q == BurstMax));
  assign grant_data  = bus.data_req & ~grant_fetch;
  assign in_fin      = (state_q == FIN) & ~rst;
  assign fin_word    = {hi_rdata_q, bus.mem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_FETCH;
      burst_q       <= '0;
      abort_q       <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      lo_wdata_q    <= '0;
      hi_rdata_q    <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      if ((state_q != IDLE) && (owner_q == OWN_FETCH) && bus.fetch_flush) begin
        abort_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (grant_fetch || grant_data) begin
            owner_q     <= grant_data ? OWN_DATA : OWN_FETCH;
            abort_q     <= 1'b0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_data & bus.data_we;
            mem_addr_q  <= grant_data ? bus.data_addr : bus.fetch_addr;
            mem_wdata_q <= grant_data ? bus.data_wdata[15:8] : '0;
            lo_wdata_q  <= grant_data ? bus.data_wdata[7:0] : '0;
            state_q     <= HI;
          end
          // Saturate so a flush-blocked fetch cannot push the count past the limit.
          if (grant_fetch) begin
            burst_q <= '0;
          end else if (grant_data) begin
            if (!bus.fetch_req) begin
              burst_q <= '0;
            end else if (burst_q != BurstMax) begin
              burst_q <= burst_q + 3'd1;
            end
          end
        end
        HI: begin
          mem_addr_q  <= mem_addr_q + ADDR_W'(1);
          mem_wdata_q <= lo_wdata_q;
          state_q     <= LO;
        end
        LO: begin
          hi_rdata_q <= bus.mem_rdata;
          mem_en_q   <= 1'b0;
          mem_we_q   <= 1'b0;
          state_q    <= FIN;
        end
        FIN: begin
          if (owner_q == OWN_FETCH) begin
            fetch_rdata_q <= fin_word;
          end else begin
            data_rdata_q <= fin_word;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are gated by reset so an interrupted store cannot write its low byte.
  assign bus.mem_en      = mem_en_q & ~rst;
  assign bus.mem_we      = mem_we_q & ~rst;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.busy        = (state_q != IDLE);

  assign bus.fetch_ack   = in_fin & (owner_q == OWN_FETCH) & ~abort_q & ~bus.fetch_flush;
  assign bus.data_ack    = in_fin & (owner_q == OWN_DATA);
  assign bus.fetch_rdata = (in_fin && owner_q == OWN_FETCH) ? fin_word : fetch_rdata_q;
  assign bus.data_rdata  = (in_fin && owner_q == OWN_DATA) ? fin_word : data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read byte memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  logic [7:0] mem [0:65535];

  mem_port_arbiter_if #(.ADDR_W(16)) bus ();

  mem_port_arbiter #(
    .ADDR_W        (16),
    .MAX_DATA_BURST(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one word access; reports ack cycle (-1 if none), data, strobe count, byte addresses.
  task automatic do_access(input bit is_data, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, output int ack_cyc,
                           output logic [15:0] rd, output int en_cnt,
                           output logic [15:0] a0, output logic [15:0] a1);
    ack_cyc = -1;
    en_cnt  = 0;
    rd      = '0;
    a0      = '0;
    a1      = '0;
    if (is_data) begin
      bus.data_req   = 1'b1;
      bus.data_we    = we;
      bus.data_addr  = addr;
      bus.data_wdata = wdata;
    end else begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = addr;
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.mem_en) begin
        if (en_cnt == 0) a0 = bus.mem_addr;
        else a1 = bus.mem_addr;
        en_cnt++;
      end
      if ((is_data ? bus.data_ack : bus.fetch_ack) && ack_cyc < 0) begin
        ack_cyc = i;
        rd      = is_data ? bus.data_rdata : bus.fetch_rdata;
        bus.data_req  = 1'b0;
        bus.fetch_req = 1'b0;
      end
      step();
    end
    bus.data_req  = 1'b0;
    bus.fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.fetch_ack, bus.data_ack} !== 2'b00)
      $display("FAIL reset_acks: got %b want 00", {bus.fetch_ack, bus.data_ack});
    else pass_cnt++;
    total_cnt++;
    if ({bus.mem_en, bus.mem_we} !== 2'b00)
      $display("FAIL reset_mem_en_we: got %b want 00", {bus.mem_en, bus.mem_we});
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.mem_addr !== 16'h0000) $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr);
    else pass_cnt++;
    total_cnt++;
    if (bus.mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata: got %h want 00", bus.mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if ({bus.fetch_rdata, bus.data_rdata} !== 32'h0)
      $display("FAIL reset_rdata: got %h/%h want 0000/0000", bus.fetch_rdata, bus.data_rdata);
    else pass_cnt++;
  endtask

  task automatic test_single_load();
    int ack_cyc, en_cnt;
    logic [15:0] rd, a0, a1;
    mem[16'h0010] = 8'hAB;
    mem[16'h0011] = 8'hCD;
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, ack_cyc, rd, en_cnt, a0, a1);
    total_cnt++;
    if (ack_cyc !== 3) $display("FAIL load_ack_latency: got %0d want 3", ack_cyc);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 16'hABCD) $display("FAIL load_rdata: got %h want abcd", rd);
    else pass_cnt++;
    total_cnt++;
    if (en_cnt !== 2) $display("FAIL load_mem_en_cycles: got %0d want 2", en_cnt);
    else pass_cnt++;
  endtask

  task automatic test_store_fetch();
    int ack_cyc, en_cnt;
    logic [15:0] rd, a0, a1;
    do_access(1'b1, 1'b1, 16'h0020, 16'h1234, ack_cyc, rd, en_cnt, a0, a1);
    total_cnt++;
    if (ack_cyc !== 3) $display("FAIL store_ack_latency: got %0d want 3", ack_cyc);
    else pass_cnt++;
    total_cnt++;
    if ({mem[16'h0020], mem[16'h0021]} !== 16'h1234)
      $display("FAIL store_bytes: got %h%h want 1234", mem[16'h0020], mem[16'h0021]);
    else pass_cnt++;
    do_access(1'b0, 1'b0, 16'h0020, 16'h0000, ack_cyc, rd, en_cnt, a0, a1);
    total_cnt++;
    if (ack_cyc !== 3) $display("FAIL fetch_ack_latency: got %0d want 3", ack_cyc);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 16'h1234) $display("FAIL fetch_rdata: got %h want 1234", rd);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int ack_cyc, en_cnt;
    logic [15:0] rd, a0, a1;
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'h01;
    do_access(1'b0, 1'b0, 16'hFFFF, 16'h0000, ack_cyc, rd, en_cnt, a0, a1);
    total_cnt++;
    if ({a0, a1} !== 32'hFFFF_0000) $display("FAIL wrap_addr_seq: got %h,%h want ffff,0000", a0, a1);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 16'h5A01) $display("FAIL wrap_rdata: got %h want 5a01", rd);
    else pass_cnt++;
  endtask

  task automatic test_starvation();
    bit exp_data [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit got_data [6];
    int got_cyc  [6];
    int n = 0;
    int both = 0;
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b0;
    bus.data_addr  = 16'h0200;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0100;
    for (int i = 0; i < 40 && n < 6; i++) begin
      #1;
      if (bus.data_ack && bus.fetch_ack) both++;
      if (bus.data_ack || bus.fetch_ack) begin
        got_data[n] = bus.data_ack;
        got_cyc[n]  = i;
        n++;
      end
      step();
    end
    bus.data_req  = 1'b0;
    bus.fetch_req = 1'b0;
    repeat (5) step();
    total_cnt++;
    if (n !== 6) $display("FAIL starve_ack_count: got %0d want 6", n);
    else pass_cnt++;
    total_cnt++;
    if (both !== 0) $display("FAIL starve_dual_ack: got %0d want 0", both);
    else pass_cnt++;
    for (int k = 0; k < n; k++) begin
      total_cnt++;
      if (got_data[k] !== exp_data[k])
        $display("FAIL starve_order[%0d]: got data=%b want data=%b", k, got_data[k], exp_data[k]);
      else pass_cnt++;
      total_cnt++;
      if (got_cyc[k] !== 3 + 4 * k)
        $display("FAIL starve_spacing[%0d]: got cycle %0d want %0d", k, got_cyc[k], 3 + 4 * k);
      else pass_cnt++;
    end
  endtask

  // Flush a fetch in the given cycle (2 = LO, 3 = FIN); the ack must not appear.
  task automatic flush_at(input int flush_cyc, input string tag);
    int acks = 0;
    logic busy_t4 = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0030;
    for (int i = 0; i < 7; i++) begin
      if (i == flush_cyc) begin
        bus.fetch_flush = 1'b1;
        bus.fetch_req   = 1'b0;
      end else begin
        bus.fetch_flush = 1'b0;
      end
      #1;
      if (bus.fetch_ack) acks++;
      if (i == 4) busy_t4 = bus.busy;
      step();
    end
    total_cnt++;
    if (acks !== 0) $display("FAIL %s_ack_suppressed: got %0d acks want 0", tag, acks);
    else pass_cnt++;
    total_cnt++;
    if (busy_t4 !== 1'b0) $display("FAIL %s_idle_t4: got busy=%b want 0", tag, busy_t4);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    flush_at(2, "flush_lo");
    flush_at(3, "flush_fin");
    // Flush in IDLE blocks a fetch grant but not a data grant.
    bus.fetch_req   = 1'b1;
    bus.fetch_flush = 1'b1;
    step();
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL flush_idle_blocks_fetch: got busy=%b want 0", bus.busy);
    else pass_cnt++;
    bus.fetch_req = 1'b0;
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_addr = 16'h0010;
    step();
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL flush_idle_data_granted: got busy=%b want 1", bus.busy);
    else pass_cnt++;
    bus.data_req    = 1'b0;
    bus.fetch_flush = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset_mid_store();
    int acks = 0;
    logic [15:0] out_addr = 16'hFFFF;
    logic [7:0]  out_wdata = 8'hFF;
    logic        out_busy = 1'b1;
    logic [1:0]  out_en_we = 2'b11;
    mem[16'h0040] = 8'h77;
    mem[16'h0041] = 8'h77;
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b1;
    bus.data_addr  = 16'h0040;
    bus.data_wdata = 16'hBEEF;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        rst          = 1'b1;
        bus.data_req = 1'b0;
      end else begin
        rst = 1'b0;
      end
      #1;
      if (bus.data_ack || bus.fetch_ack) acks++;
      if (i == 3) begin
        out_addr  = bus.mem_addr;
        out_wdata = bus.mem_wdata;
        out_busy  = bus.busy;
        out_en_we = {bus.mem_en, bus.mem_we};
      end
      step();
    end
    total_cnt++;
    if (acks !== 0) $display("FAIL rst_store_no_ack: got %0d acks want 0", acks);
    else pass_cnt++;
    total_cnt++;
    if (out_busy !== 1'b0) $display("FAIL rst_store_idle: got busy=%b want 0", out_busy);
    else pass_cnt++;
    total_cnt++;
    if ({out_en_we, out_addr, out_wdata} !== 26'h0)
      $display("FAIL rst_store_outputs: got en_we=%b addr=%h wdata=%h want 00/0000/00",
               out_en_we, out_addr, out_wdata);
    else pass_cnt++;
    total_cnt++;
    if (mem[16'h0040] !== 8'hBE) $display("FAIL rst_store_hi_byte: got %h want be", mem[16'h0040]);
    else pass_cnt++;
    total_cnt++;
    if (mem[16'h0041] !== 8'h77) $display("FAIL rst_store_lo_byte: got %h want 77", mem[16'h0041]);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    rst             = 1'b1;
    bus.fetch_req   = 1'b0;
    bus.fetch_addr  = '0;
    bus.fetch_flush = 1'b0;
    bus.data_req    = 1'b0;
    bus.data_we     = 1'b0;
    bus.data_addr   = '0;
    bus.data_wdata  = '0;
    bus.mem_rdata   = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    test_reset();
    test_single_load();
    test_store_fetch();
    test_wrap();
    test_starvation();
    test_flush();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
